alu_result_log: RTL
===================

# alu_result_log

Circular history buffer sitting directly downstream of the ALU result and status registers on the DE10-Lite datapath. Captures each committed 8-bit result together with its V/C/Neg/Z flags when the C register loads, holds the last DEPTH entries, and lets the user browse them newest-to-oldest with a push-button so a HEX pair and LEDs can replay earlier operations. All state is clocked by the 50 MHz board clock; capture and browse inputs are debounced levels, edge-detected internally.

## Interface
- N, 8, result width in bits
- DEPTH, 8, number of stored entries; power of two, ≥2
- CLK50M  in  1  50 MHz board clock; all state updates on rising edge
- RSTb  in  1  asynchronous active-low reset
- Capture  in  1  debounced level; rising edge commits an entry (driven from the C-register load strobe)
- Result  in  N  value to store (C register output)
- Flags  in  4  {V,C,Neg,Z} to store (status register output)
- Next  in  1  debounced level; rising edge steps view to the next-older entry
- Clear  in  1  synchronous clear, level-sensitive, active-high
- View  out  N  result of entry currently viewed
- ViewFlags  out  4  flags of entry currently viewed
- ViewIdx  out  $clog2(DEPTH)  age of viewed entry; 0 = newest
- Count  out  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- Empty  out  1  Count == 0
- Full  out  1  Count == DEPTH

## Operation
- State: storage array DEPTH×(N+4), write pointer wp, Count, ViewIdx, edge-detect registers capPrev, nextPrev.
- Edge detection: capEdge = Capture & ~capPrev; nextEdge = Next & ~nextPrev; prev registers load input every cycle.
- Priority per cycle: Clear > capEdge > nextEdge; lower-priority event in the same cycle is discarded, not deferred.
- Clear: wp←0, Count←0, ViewIdx←0; storage contents need not be zeroed.
- capEdge: mem[wp]←{Flags,Result}; wp←wp+1 mod DEPTH; Count←min(Count+1, DEPTH); ViewIdx←0. When full, the oldest entry is overwritten.
- nextEdge: if Count==0 no change; else ViewIdx←(ViewIdx+1) mod Count, i.e. after the oldest entry it wraps to the newest.
- Read: View/ViewFlags = mem[(wp−1−ViewIdx) mod DEPTH]; when Empty both are forced to 0.
- Result and Flags are stored unmodified; no arithmetic on data.

## Timing
- Reset values: wp=0, Count=0, ViewIdx=0, View=0, ViewFlags=0, Empty=1, Full=0, capPrev=1, nextPrev=1.
- Prev registers reset to 1: an input already held high when RSTb deasserts produces no edge; it must go low then high.
- Input sampled high at edge t with prev low: state updates at edge t; View, Count and flags reflect it immediately after t (one-cycle latency from the sampling edge, combinational read).
- A held-high input produces exactly one event.
- Reset mid-browse or mid-capture: all state returns to reset values asynchronously; an in-flight edge is lost.
- Capture and Next edges in the same cycle: entry written, ViewIdx=0, Next ignored.

## Configuration
- ALU_LOG_SATURATE_EN defined: capEdge while Full is ignored (no write, wp/Count/ViewIdx unchanged); the log freezes on the first DEPTH results until Clear.
- Undefined (default): capEdge while Full overwrites the oldest entry as described above.

## Test plan
- Reset with Capture held high, release RSTb -> no entry; Count=0, Empty=1, View=0x00; drop then raise Capture with Result=0x3C, Flags=4'b0000 -> Count=1, View=0x3C.
- Capture 0x01, 0x02, 0x03 then pulse Next 3 times -> View 0x03→0x02→0x01→0x03, ViewIdx 0→1→2→0.
- Capture 0x10..0x19 (10 entries) -> Full=1, Count=8; seven Next pulses walk View 0x19 down to 0x12; eighth Next returns to 0x19. With ALU_LOG_SATURATE_EN: Count=8, newest View=0x17.
- Capture Result=0x80, Flags=4'b1010 -> ViewFlags=4'b1010, View=0x80.
- Capture and Next rising on the same cycle with ViewIdx=2 -> new entry shown, ViewIdx=0; Clear asserted with a Capture edge -> Count=0, Empty=1, View=0x00.
- Next pulse while Empty -> ViewIdx stays 0, outputs unchanged; assert RSTb low mid-browse (ViewIdx=3) -> all outputs return to reset values without a clock.

Source files
------------

// File: rtl/alu_result_log.sv
// Circular history of committed ALU results and status flags, browsable newest-to-oldest.
// Optional build macro ALU_LOG_SATURATE_EN: freeze the log once full instead of overwriting.
module alu_result_log #(
  parameter int N     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK50M,
  input  logic                     RSTb,
  input  logic                     Capture,
  input  logic [N-1:0]             Result,
  input  logic [3:0]               Flags,
  input  logic                     Next,
  input  logic                     Clear,
  output logic [N-1:0]             View,
  output logic [3:0]               ViewFlags,
  output logic [$clog2(DEPTH)-1:0] ViewIdx,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [N+3:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_viewIdx;
  logic          r_capPrev;
  logic          r_nextPrev;

  logic          w_capEdge;
  logic          w_nextEdge;
  logic          w_capWrite;
  logic          w_empty;
  logic          w_full;
  logic          w_idxWrap;
  logic [AW-1:0] w_rdAddr;
  logic [N+3:0]  w_rdWord;

  assign w_capEdge  = Capture & ~r_capPrev;
  assign w_nextEdge = Next & ~r_nextPrev;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);

`ifdef ALU_LOG_SATURATE_EN
  // A capture edge on a full log is still consumed, so a same-cycle Next is dropped too.
  assign w_capWrite = w_capEdge & ~w_full;
`else
  assign w_capWrite = w_capEdge;
`endif

  // Browsing wraps from the oldest valid entry back to the newest.
  assign w_idxWrap = ((AW+1)'(r_viewIdx) + (AW+1)'(1)) == r_count;

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      r_capPrev  <= 1'b1;
      r_nextPrev <= 1'b1;
      r_wp       <= '0;
      r_count    <= '0;
      r_viewIdx  <= '0;
    end else begin
      r_capPrev  <= Capture;
      r_nextPrev <= Next;
      if (Clear) begin
        r_wp      <= '0;
        r_count   <= '0;
        r_viewIdx <= '0;
      end else if (w_capEdge) begin
        if (w_capWrite) begin
          r_wp      <= r_wp + AW'(1);
          r_viewIdx <= '0;
          if (!w_full)
            r_count <= r_count + (AW+1)'(1);
        end
      end else if (w_nextEdge && !w_empty) begin
        r_viewIdx <= w_idxWrap ? '0 : r_viewIdx + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK50M) begin
    if (!Clear && w_capWrite)
      r_mem[r_wp] <= {Flags, Result};
  end

  // Newest entry sits just behind the write pointer; DEPTH is a power of two so wrap is free.
  assign w_rdAddr = r_wp - AW'(1) - r_viewIdx;
  assign w_rdWord = r_mem[w_rdAddr];

  always_comb begin
    View      = '0;
    ViewFlags = '0;
    if (!w_empty) begin
      View      = w_rdWord[N-1:0];
      ViewFlags = w_rdWord[N+3:N];
    end
  end

  assign ViewIdx = r_viewIdx;
  assign Count   = r_count;
  assign Empty   = w_empty;
  assign Full    = w_full;

endmodule
